// File: rtl/button_event_queue.sv
// Arbitrates per-button press pulses lowest-index-first into a small FWFT FIFO
// drained by a valid/ready consumer; merged presses raise a sticky overflow flag.

module button_event_pending_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic press,
    input  logic grant,
    output logic pend,
    output logic drop
);

    // A press on an ungranted pending bit merges into the existing event.
    assign drop = press & pend & ~grant;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pend <= 1'b0;
        else          pend <= (pend & ~grant) | press;
    end

endmodule

module button_event_queue #(
    parameter int CODE_W = 2,
    parameter int ADDR_W = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2**CODE_W-1:0] press,
    output logic                 evt_valid,
    output logic [CODE_W-1:0]    evt_code,
    input  logic                 evt_ready,
    output logic [ADDR_W:0]      count,
    output logic                 overflow,
    input  logic                 clr_overflow
);

    localparam int N     = 2**CODE_W;
    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

    logic [N-1:0]        pend;
    logic [N-1:0]        grant_vec;
    logic [N-1:0]        drop_vec;
    logic [CODE_W-1:0]   grant_code;
    logic                found;
    logic                push;
    logic                pop;
    logic                room;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     count_q;
    logic [CODE_W-1:0]   mem [DEPTH];

    button_event_pending_cell u_cell [N-1:0] (
        .clk     (clk),
        .reset_n (reset_n),
        .press   (press),
        .grant   (grant_vec),
        .pend    (pend),
        .drop    (drop_vec)
    );

    assign count     = count_q;
    assign evt_valid = (count_q != '0);
    assign pop       = evt_valid & evt_ready;
    assign room      = (count_q < DEPTH_CNT);
    assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

    // Only the registered pending vector is arbitrated; a pop frees a slot
    // in the same cycle, so a full queue still accepts when it is drained.
    always_comb begin
        grant_code = '0;
        found      = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (pend[i] && !found) begin
                grant_code = CODE_W'(i);
                found      = 1'b1;
            end
        end
        push      = found & (room | pop);
        grant_vec = push ? ({{(N-1){1'b0}}, 1'b1} << grant_code) : '0;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= grant_code;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (|drop_vec)         overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_queue.sv
// Scoreboard bench: stimulus queues expected codes, a negedge monitor checks pops.

module tb_button_event_queue;

    localparam int CODE_W = 2;
    localparam int ADDR_W = 3;
    localparam int N      = 4;

    logic              clk;
    logic              reset_n;
    logic [N-1:0]      press;
    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_ready;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              clr_overflow;

    int total = 0;
    int bad   = 0;
    logic [CODE_W-1:0] exp_q [$];
    logic [CODE_W-1:0] exp_code;

    button_event_queue #(.CODE_W(CODE_W), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .press        (press),
        .evt_valid    (evt_valid),
        .evt_code     (evt_code),
        .evt_ready    (evt_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int code);
        press = N'(1) << code;
        tick();
        press = '0;
    endtask

    task automatic drain(input string name);
        evt_ready = 1'b1;
        for (int i = 0; i < 40 && count != 0; i++) tick();
        tick();
        evt_ready = 1'b0;
        check({name, "_count_empty"}, int'(count), 0);
        check({name, "_scoreboard_empty"}, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got code %0d expected none", evt_code);
            end else begin
                exp_code = exp_q.pop_front();
                check("evt_code_order", int'(evt_code), int'(exp_code));
            end
        end
    end

    initial begin
        logic r;
        int   code;
        reset_n      = 1'b0;
        press        = '0;
        evt_ready    = 1'b0;
        clr_overflow = 1'b0;
        repeat (3) tick();
        check("rst_valid", int'(evt_valid), 0);
        check("rst_code", int'(evt_code), 0);
        check("rst_count", int'(count), 0);
        check("rst_overflow", int'(overflow), 0);
        reset_n = 1'b1;
        repeat (6) tick();

        // single event, latency two edges
        exp_q.push_back(2'd2);
        pulse(2);
        check("single_not_yet", int'(evt_valid), 0);
        tick();
        check("single_valid", int'(evt_valid), 1);
        check("single_code", int'(evt_code), 2);
        check("single_count", int'(count), 1);
        drain("single");

        // simultaneous presses, ascending order
        evt_ready = 1'b1;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd3);
        press = 4'b1011;
        tick();
        press = '0;
        repeat (6) tick();
        check("simul_valid", int'(evt_valid), 0);
        check("simul_overflow", int'(overflow), 0);
        check("simul_sb_empty", exp_q.size(), 0);
        evt_ready = 1'b0;

        // fill to full
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(CODE_W'(i % 4));
            pulse(i % 4);
        end
        repeat (3) tick();
        check("full_count", int'(count), 8);
        exp_q.push_back(2'd2);
        pulse(2);
        repeat (2) tick();
        check("full_hold_count", int'(count), 8);
        check("full_pend2", int'(dut.pend[2]), 1);
        check("full_no_overflow", int'(overflow), 0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check("full_pop_push_count", int'(count), 8);
        check("full_pend_cleared", int'(dut.pend), 0);

        // drops while full
        exp_q.push_back(2'd1);
        pulse(1);
        repeat (4) tick();
        check("drop_first_no_ovf", int'(overflow), 0);
        pulse(1);
        check("drop_ovf_set", int'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("drop_ovf_cleared", int'(overflow), 0);
        press        = 4'b0010;
        clr_overflow = 1'b1;
        tick();
        press        = '0;
        clr_overflow = 1'b0;
        check("drop_set_beats_clr", int'(overflow), 1);
        clr_overflow = 1'b1;
        tick();
        clr_overflow = 1'b0;
        check("drop_ovf_cleared2", int'(overflow), 0);
        check("drop_count", int'(count), 8);
        drain("full");

        // re-press during grant
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        press = 4'b0001;
        tick();
        tick();
        press = '0;
        repeat (3) tick();
        check("repress_count", int'(count), 2);
        check("repress_overflow", int'(overflow), 0);
        drain("repress");

        // streaming across pointer wrap
        r = 1'b0;
        for (int i = 0; i < 20; i++) begin
            code = (i * 3 + 1) % 4;
            exp_q.push_back(CODE_W'(code));
            press     = N'(1) << code;
            evt_ready = r;
            tick();
            press     = '0;
            evt_ready = ~r;
            tick();
        end
        for (int i = 0; i < 60 && count != 0; i++) begin
            evt_ready = r;
            r = ~r;
            tick();
        end
        evt_ready = 1'b0;
        check("wrap_count", int'(count), 0);
        check("wrap_sb_empty", exp_q.size(), 0);
        check("wrap_overflow", int'(overflow), 0);

        // mid-operation reset (these events are discarded, never expected)
        for (int i = 0; i < 5; i++) pulse(i % 4);
        repeat (3) tick();
        check("mid_count5", int'(count), 5);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_valid", int'(evt_valid), 0);
        check("mid_rst_code", int'(evt_code), 0);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post_rst_count", int'(count), 0);
        check("post_rst_pend", int'(dut.pend), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_event_queue.md
# button_event_queue

Collects the single-cycle press pulses produced by the per-button `debounce` instances and turns them into an ordered stream of button codes for the game logic. Simultaneous presses are arbitrated lowest-index-first and buffered in a small FIFO. The consumer drains the FIFO through a valid/ready handshake. No press is lost while the queue has room; drops are flagged on a sticky overflow bit.

## Interface
- `CODE_W`, default 2: button code width; number of buttons `N = 2**CODE_W`.
- `ADDR_W`, default 3: FIFO address width; depth `DEPTH = 2**ADDR_W`.

Ports:
- `clk`  in  1  system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `press`  in  N  one-cycle press pulses; bit i comes from the debounce instance of button i.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_code`  out  CODE_W  button index at FIFO head; forced to 0 when `evt_valid=0`.
- `evt_ready`  in  1  consumer accepts the head this cycle.
- `count`  out  ADDR_W+1  events currently stored, 0..DEPTH.
- `overflow`  out  1  sticky; a press was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Pending register `P[N-1:0]`, one bit per button, sits between `press` and the FIFO.
- Grant:
  - Each cycle, `g` = lowest set bit of registered `P`.
  - Only registered `P` is considered; raw `press` is never granted the same cycle.
  - Grant is issued when `P != 0` and the FIFO can accept: `count < DEPTH`, or a pop occurs this cycle.
- Push: the granted index `g` is written at `wr_ptr`. `wr_ptr` increments mod DEPTH.
- Pending update: `P_next[i] = (P[i] & ~grant_i) | press[i]`.
- Overflow and back-pressure:
  - `press[i]` while `P[i]=1` and bit i is not granted this cycle: the press merges into the existing pending event. This counts as a drop and sets `overflow`.
  - `press[i]` in the same cycle bit i is granted: `P[i]` stays 1, giving a new event; no overflow.
  - FIFO full and no pop: no grant. Pending bits are held, not dropped. Back-pressure propagates only into `P`.
- Pop:
  - When `evt_valid & evt_ready`, `rd_ptr` increments mod DEPTH.
  - `evt_code` is first-word-fall-through: the value at `mem[rd_ptr]`, combinationally gated to 0 when empty.
- Count: +1 on push only, −1 on pop only, unchanged on both or neither.
  - Push and pop in the same cycle are legal at any fill level, including full and `count=1`.
- `evt_ready` while empty has no effect.
- Overflow flag:
  - Set has priority over `clr_overflow` in the same cycle.
  - Otherwise `clr_overflow=1` clears it.
- Pointers wrap naturally at DEPTH. Full vs empty is distinguished by `count`, not by pointer equality.

## Timing
- Reset values (asynchronous, while `reset_n=0`):
  - `P=0`, `wr_ptr=rd_ptr=0`, `count=0`, `evt_valid=0`, `evt_code=0`, `overflow=0`.
  - FIFO memory is not reset.
- Reset asserted mid-operation discards all pending and queued events immediately.
- Latency:
  - `press[i]` high in cycle t sets `P[i]` at edge t+1.
  - It is granted and written at edge t+2 if it is the lowest pending bit and there is room.
  - With an empty queue, `evt_valid=1` and `evt_code=i` from cycle t+2.
- Throughput: one push and one pop per cycle maximum. k simultaneous presses enter the FIFO over k consecutive cycles, ascending index.
- `count` and `evt_valid` are registered-state derived and glitch-free. `evt_valid = (count != 0)`.

## Test plan
- **Reset and single event:** hold `reset_n=0` 3 cycles, check all outputs 0. Then pulse `press=4'b0100` at cycle 10, `evt_ready=0` → `evt_valid=1`, `evt_code=2`, `count=1` at cycle 12.
- **Simultaneous presses:** `press=4'b1011` for one cycle, `evt_ready=1` → codes 0,1,3 accepted on consecutive cycles, then `evt_valid=0`, `overflow=0`.
- **Full FIFO:**
  - `evt_ready=0`, press 8 single events → `count=8`.
  - Press button 2 → `count` stays 8, `P[2]=1`, no overflow.
  - Raise `evt_ready` for one cycle → pop and the push of code 2 happen in the same cycle, `count` stays 8.
- **Drop:** with the FIFO full, press button 1 twice, 5 cycles apart → `overflow=1` after the second press. `clr_overflow` then clears it. A same-cycle press on another pending bit plus `clr_overflow` leaves it set.
- **Re-press during grant:** `press[0]` at t and again at t+1 → two code-0 events queued, no overflow.
- **Wrap and mid-operation reset:**
  - Stream 20 events with `evt_ready` toggling every cycle → order preserved across pointer wrap.
  - Assert `reset_n=0` with `count=5` → `count=0` and `evt_valid=0` immediately, with no clock edge needed.
